regfile_8x: RTL and testbench

- 8-entry, WIDTH-bit general-purpose register file for the ID stage of the 5-stage pipeline.
- It has two combinational read ports (A and B), one synchronous write port fed by WB, and write-to-read bypass so WB→ID needs no extra stall.
- Each read port selects its entry through the existing mux_8 bit-slice selector.
- Register 0 is hardwired to zero.

---
 rtl/regfile_8x_pkg.sv | 7 +
 rtl/mux_8.sv | 8 +
 rtl/regfile_read_port.sv | 45 ++++
 rtl/regfile_8x.sv | 48 ++++
 tb/tb_regfile_8x.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/regfile_8x_pkg.sv
// Register-file constants shared by the register file and the ID/WB hazard logic.
package regfile_8x_pkg;
  localparam int              REG_ADDR_W = 3;
  localparam int              NUM_REGS   = 8;
  localparam logic [2:0]      REG_ZERO   = 3'd0;
  localparam int              DATA_W     = 16;
endpackage

// File: rtl/mux_8.sv
// One-bit 8:1 selector used as a bit slice of the register-file read ports.
module mux_8 (
  input  logic [7:0] i_d,
  input  logic [2:0] i_sel,
  output logic       o_y
);
  always_comb o_y = i_d[i_sel];
endmodule

// File: rtl/regfile_read_port.sv
// Combinational read port: per-bit mux_8 select, WB bypass, zero-register and reset override.
// Zero latency; no flow control.
module regfile_read_port
  import regfile_8x_pkg::*;
#(
  parameter int WIDTH    = DATA_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                           i_rst,
  input  logic                           i_we,
  input  logic [REG_ADDR_W-1:0]          i_waddr,
  input  logic [WIDTH-1:0]               i_wdata,
  input  logic [REG_ADDR_W-1:0]          i_raddr,
  input  logic [NUM_REGS-1:0][WIDTH-1:0] i_regs,
  output logic [WIDTH-1:0]               o_rdata
);
  logic [WIDTH-1:0] w_mux;
  logic             w_zero;
  logic             w_hit;

  genvar b, k;
  generate
    for (b = 0; b < WIDTH; b++) begin : g_bit
      logic [NUM_REGS-1:0] w_slice;
      for (k = 0; k < NUM_REGS; k++) begin : g_ent
        assign w_slice[k] = i_regs[k][b];
      end
      mux_8 u_mux (
        .i_d  (w_slice),
        .i_sel(i_raddr),
        .o_y  (w_mux[b])
      );
    end
  endgenerate

  // A dropped write to the zero register must never bypass.
  assign w_zero = ZERO_REG && (i_raddr == REG_ZERO);
  assign w_hit  = i_we && (i_waddr == i_raddr) && !(ZERO_REG && (i_waddr == REG_ZERO));

  always_comb begin
    o_rdata = w_mux;
    if (i_rst || w_zero) o_rdata = '0;
    else if (w_hit)      o_rdata = i_wdata;
  end
endmodule

// File: rtl/regfile_8x.sv
// 8-entry register file: two zero-latency read ports with WB bypass, one synchronous write port.
// Reset clears every entry and wins over a same-cycle write.
module regfile_8x
  import regfile_8x_pkg::*;
#(
  parameter int WIDTH    = DATA_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [REG_ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic [REG_ADDR_W-1:0] i_raddr_a,
  input  logic [REG_ADDR_W-1:0] i_raddr_b,
  output logic [WIDTH-1:0]      o_rdata_a,
  output logic [WIDTH-1:0]      o_rdata_b
);
  logic [NUM_REGS-1:0][WIDTH-1:0] r_regs;
  logic                           w_wr_en;

  assign w_wr_en = i_we && !(ZERO_REG && (i_waddr == REG_ZERO));

  always_ff @(posedge i_clk) begin
    if (i_rst)        r_regs <= '0;
    else if (w_wr_en) r_regs[i_waddr] <= i_wdata;
  end

  regfile_read_port #(.WIDTH(WIDTH), .ZERO_REG(ZERO_REG)) u_port_a (
    .i_rst  (i_rst),
    .i_we   (i_we),
    .i_waddr(i_waddr),
    .i_wdata(i_wdata),
    .i_raddr(i_raddr_a),
    .i_regs (r_regs),
    .o_rdata(o_rdata_a)
  );

  regfile_read_port #(.WIDTH(WIDTH), .ZERO_REG(ZERO_REG)) u_port_b (
    .i_rst  (i_rst),
    .i_we   (i_we),
    .i_waddr(i_waddr),
    .i_wdata(i_wdata),
    .i_raddr(i_raddr_b),
    .i_regs (r_regs),
    .o_rdata(o_rdata_b)
  );
endmodule

// File: tb/tb_regfile_8x.sv
// Bench for regfile_8x: directed vector table, zero-register rebuild, then random traffic vs. a model.
module tb_regfile_8x;
  logic        clk = 1'b0;
  logic        rst, we;
  logic [2:0]  waddr, ra, rb;
  logic [15:0] wdata;
  logic [15:0] a, b, na, nb;

  int total = 0;
  int bad   = 0;

  int mem_z [8];
  int mem_n [8];

  typedef struct {
    logic        rst;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    string       name;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  regfile_8x #(.WIDTH(16), .ZERO_REG(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
    .i_raddr_a(ra), .i_raddr_b(rb), .o_rdata_a(a), .o_rdata_b(b)
  );

  regfile_8x #(.WIDTH(16), .ZERO_REG(1'b0)) dut_nz (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
    .i_raddr_a(ra), .i_raddr_b(rb), .o_rdata_a(na), .o_rdata_b(nb)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // What a read of addr should return this cycle, from the behavioural rules.
  function automatic logic [15:0] model_rd(input bit zr, input logic [2:0] addr);
    int v;
    if (rst) return 16'h0;
    if (zr && addr == 0) return 16'h0;
    if (we && waddr == addr && !(zr && waddr == 0)) return wdata;
    v = zr ? mem_z[addr] : mem_n[addr];
    return 16'(v);
  endfunction

  task automatic drive(input logic r, input logic w, input logic [2:0] wa, input logic [15:0] wd,
                       input logic [2:0] a_addr, input logic [2:0] b_addr);
    rst = r; we = w; waddr = wa; wdata = wd; ra = a_addr; rb = b_addr;
    #2;
    chk("model_a",    a,  model_rd(1'b1, ra));
    chk("model_b",    b,  model_rd(1'b1, rb));
    chk("model_nz_a", na, model_rd(1'b0, ra));
    chk("model_nz_b", nb, model_rd(1'b0, rb));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) begin mem_z[i] = 0; mem_n[i] = 0; end
    end else if (we) begin
      if (waddr != 0) mem_z[waddr] = int'(wdata);
      mem_n[waddr] = int'(wdata);
    end
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic [2:0] wa, input logic [15:0] wd,
                              input logic [2:0] a_addr, input logic [2:0] b_addr,
                              input logic [15:0] ea, input logic [15:0] eb, input string nm);
    vec_t v;
    v.rst = r; v.we = w; v.waddr = wa; v.wdata = wd; v.ra = a_addr; v.rb = b_addr;
    v.exp_a = ea; v.exp_b = eb; v.name = nm;
    return v;
  endfunction

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; ra = '0; rb = '0;
    for (int i = 0; i < 8; i++) begin mem_z[i] = 0; mem_n[i] = 0; end

    vecs.push_back(mk(1, 0, 0, 16'h0, 1, 2, 16'h0, 16'h0, "reset_state"));
    for (int k = 1; k < 8; k++)
      vecs.push_back(mk(0, 1, 3'(k), 16'hFFFF, 3'(k), 0, 16'hFFFF, 16'h0, "fill_ffff"));
    vecs.push_back(mk(1, 0, 0, 16'h0, 1, 7, 16'h0, 16'h0, "rst_cycle_reads0"));
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(0, 0, 0, 16'h0, 3'(k), 3'(7 - k), 16'h0, 16'h0, "post_rst_clear"));
    for (int k = 1; k < 8; k++)
      vecs.push_back(mk(0, 1, 3'(k), 16'(16'h1111 * k), 3'(k), 0, 16'(16'h1111 * k), 16'h0, "sweep_write"));
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(0, 0, 0, 16'h0, 3'(k), 3'(7 - k),
                        16'(16'h1111 * k), 16'(16'h1111 * (7 - k)), "sweep_read"));
    vecs.push_back(mk(0, 1, 3, 16'h00AA, 0, 0, 16'h0, 16'h0, "set_e3"));
    vecs.push_back(mk(0, 0, 0, 16'h0, 3, 3, 16'h00AA, 16'h00AA, "e3_old"));
    vecs.push_back(mk(0, 1, 3, 16'h5A5A, 3, 3, 16'h5A5A, 16'h5A5A, "bypass_both"));
    vecs.push_back(mk(0, 0, 0, 16'h0, 3, 3, 16'h5A5A, 16'h5A5A, "bypass_next"));
    vecs.push_back(mk(0, 1, 4, 16'h4444, 1, 5, 16'h1111, 16'h5555, "set_e4"));
    vecs.push_back(mk(0, 1, 2, 16'h0F0F, 2, 4, 16'h0F0F, 16'h4444, "indep_ports"));
    vecs.push_back(mk(0, 0, 0, 16'h0, 2, 4, 16'h0F0F, 16'h4444, "indep_after"));
    vecs.push_back(mk(0, 1, 0, 16'hBEEF, 0, 0, 16'h0, 16'h0, "zero_wr"));
    vecs.push_back(mk(0, 0, 0, 16'h0, 0, 3, 16'h0, 16'h5A5A, "zero_after"));
    vecs.push_back(mk(1, 1, 5, 16'h1234, 5, 5, 16'h0, 16'h0, "rst_vs_wr"));
    vecs.push_back(mk(0, 0, 0, 16'h0, 5, 3, 16'h0, 16'h0, "rst_vs_wr_after"));

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].ra, vecs[i].rb);
      chk({vecs[i].name, "_a"}, a, vecs[i].exp_a);
      chk({vecs[i].name, "_b"}, b, vecs[i].exp_b);
      tick();
    end

    // Entry 0 is an ordinary register in the ZERO_REG=0 build.
    drive(0, 1, 0, 16'hBEEF, 0, 0);
    chk("nz_zero_bypass", na, 16'hBEEF);
    chk("z_zero_bypass",  a,  16'h0000);
    tick();
    drive(0, 0, 0, 16'h0, 0, 1);
    chk("nz_zero_stored", na, 16'hBEEF);
    chk("z_zero_stored",  a,  16'h0000);
    tick();
    drive(1, 1, 0, 16'h7777, 0, 0);
    chk("nz_rst_override", na, 16'h0000);
    tick();
    drive(0, 0, 0, 16'h0, 0, 0);
    chk("nz_rst_cleared", na, 16'h0000);
    tick();

    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 19) == 0), 1'($urandom), 3'($urandom), 16'($urandom),
            3'($urandom), 3'($urandom));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
